// File: rtl/s_core_boot_pkg.sv
// s_core_boot_pkg: opcodes, FSM state encoding and byte-count width for the s_core boot loader.
// The CSUM state exists only when LOADER_CSUM_EN is defined.
package s_core_boot_pkg;
    localparam logic [7:0] OP_IMEM  = 8'h01;
    localparam logic [7:0] OP_REG   = 8'h02;
    localparam logic [7:0] OP_START = 8'h03;
    localparam int CNT_W = 2;
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ADDR   = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_CSUM   = 3'd3;
    localparam logic [2:0] ST_COMMIT = 3'd4;
    localparam logic [2:0] ST_RUN    = 3'd5;
    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_ADDR   = ST_ADDR,
        S_DATA   = ST_DATA,
        S_COMMIT = ST_COMMIT,
`ifdef LOADER_CSUM_EN
        S_RUN    = ST_RUN,
        S_CSUM   = ST_CSUM
`else
        S_RUN    = ST_RUN
`endif
    } state_t;
    function automatic logic op_known(input logic [7:0] op);
        return (op == OP_IMEM) || (op == OP_REG) || (op == OP_START);
    endfunction
endpackage

// File: rtl/s_core_boot_loader_asm.sv
// boot_word_asm: 8->32 little-endian byte assembler; first byte lands in bits [7:0] after four loads.
module boot_word_asm
    import s_core_boot_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_ld,
    input  logic [7:0]       i_byte,
    output logic [31:0]      o_word_nxt,
    output logic [CNT_W-1:0] o_cnt
);
    logic [31:0]      r_word;
    logic [CNT_W-1:0] r_cnt;

    // Look-ahead word lets the commit capture a byte arriving on the same edge.
    assign o_word_nxt = i_ld ? {i_byte, r_word[31:8]} : r_word;
    assign o_cnt      = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (i_clr) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (i_ld) begin
            r_word <= o_word_nxt;
            r_cnt  <= r_cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/s_core_boot_loader.sv
// s_core_boot_loader: parses IMEM/REG/START byte records into s_core setup writes and PC start.
// Define LOADER_CSUM_EN to require a trailing XOR checksum byte on every record.
module s_core_boot_loader
    import s_core_boot_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_rx_ready,
    output logic              o_setup,
    output logic [ADDR_W-1:0] o_inst_mem_addr,
    output logic [DATA_W-1:0] o_inst_mem_data,
    output logic              o_inst_mem_we,
    output logic [REG_AW-1:0] o_load_reg_addr,
    output logic [DATA_W-1:0] o_load_reg_data,
    output logic              o_load_reg_we,
    output logic [ADDR_W-1:0] o_pc_instr_start_addr,
    output logic              o_err
);
    state_t            r_state, w_nxt;
    logic [7:0]        r_op;
    logic              r_rdy, r_err, r_iwe, r_rwe;
    logic [ADDR_W-1:0] r_imem_addr, r_pc;
    logic [DATA_W-1:0] r_imem_data, r_reg_data;
    logic [REG_AW-1:0] r_reg_addr;
    logic              w_hs, w_clr, w_a_ld, w_d_ld, w_commit, w_start, w_bad;
    logic [31:0]       w_a_nxt, w_d_nxt;
    logic [CNT_W-1:0]  w_a_cnt, w_d_cnt;
    logic [REG_AW-1:0] w_idx;
`ifdef LOADER_CSUM_EN
    logic [7:0]        r_csum;
`endif

    assign o_rx_ready            = r_rdy & (r_state != S_COMMIT) & (r_state != S_RUN);
    assign o_setup               = r_state != S_RUN;
    assign o_inst_mem_addr       = r_imem_addr;
    assign o_inst_mem_data       = r_imem_data;
    assign o_inst_mem_we         = r_iwe;
    assign o_load_reg_addr       = r_reg_addr;
    assign o_load_reg_data       = r_reg_data;
    assign o_load_reg_we         = r_rwe;
    assign o_pc_instr_start_addr = r_pc;
    assign o_err                 = r_err;
    assign w_hs                  = i_rx_valid & o_rx_ready;
    assign w_clr                 = r_state == S_IDLE;
    // A REG record's single index byte sits in the top byte of the address assembler.
    assign w_idx                 = w_a_nxt[24 +: REG_AW];

    boot_word_asm u_addr (
        .clk(clk), .rst_n(rst_n), .i_clr(w_clr), .i_ld(w_a_ld), .i_byte(i_rx_data),
        .o_word_nxt(w_a_nxt), .o_cnt(w_a_cnt)
    );
    boot_word_asm u_data (
        .clk(clk), .rst_n(rst_n), .i_clr(w_clr), .i_ld(w_d_ld), .i_byte(i_rx_data),
        .o_word_nxt(w_d_nxt), .o_cnt(w_d_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_nxt;
    end

    always_comb begin
        w_nxt    = r_state;
        w_a_ld   = 1'b0;
        w_d_ld   = 1'b0;
        w_commit = 1'b0;
        w_start  = 1'b0;
        w_bad    = 1'b0;
        case (r_state)
            S_IDLE: if (w_hs) begin
                w_bad = !op_known(i_rx_data);
                w_nxt = w_bad ? S_IDLE : S_ADDR;
            end
            S_ADDR: if (w_hs) begin
                w_a_ld = 1'b1;
                if (r_op == OP_REG || w_a_cnt == '1) begin
`ifdef LOADER_CSUM_EN
                    w_nxt = (r_op == OP_START) ? S_CSUM : S_DATA;
`else
                    w_start = r_op == OP_START;
                    w_nxt   = w_start ? S_RUN : S_DATA;
`endif
                end
            end
            S_DATA: if (w_hs) begin
                w_d_ld = 1'b1;
                if (w_d_cnt == '1) begin
`ifdef LOADER_CSUM_EN
                    w_nxt = S_CSUM;
`else
                    w_commit = 1'b1;
                    w_nxt    = S_COMMIT;
`endif
                end
            end
`ifdef LOADER_CSUM_EN
            S_CSUM: if (w_hs) begin
                w_bad    = i_rx_data != r_csum;
                w_start  = !w_bad && r_op == OP_START;
                w_commit = !w_bad && r_op != OP_START;
                w_nxt    = w_bad ? S_IDLE : (w_start ? S_RUN : S_COMMIT);
            end
`endif
            S_COMMIT: w_nxt = S_IDLE;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op        <= '0;
            r_rdy       <= 1'b0;
            r_err       <= 1'b0;
            r_iwe       <= 1'b0;
            r_rwe       <= 1'b0;
            r_imem_addr <= '0;
            r_imem_data <= '0;
            r_reg_addr  <= '0;
            r_reg_data  <= '0;
            r_pc        <= '0;
`ifdef LOADER_CSUM_EN
            r_csum      <= '0;
`endif
        end else begin
            r_rdy <= 1'b1;
            r_err <= r_err | w_bad;
            r_iwe <= w_commit && r_op == OP_IMEM;
            r_rwe <= w_commit && r_op == OP_REG && w_idx != '0;
            if (w_clr && w_hs) r_op <= i_rx_data;
            if (w_commit && r_op == OP_IMEM) begin
                r_imem_addr <= w_a_nxt[ADDR_W-1:0];
                r_imem_data <= w_d_nxt[DATA_W-1:0];
            end
            if (w_commit && r_op == OP_REG && w_idx != '0) begin
                r_reg_addr <= w_idx;
                r_reg_data <= w_d_nxt[DATA_W-1:0];
            end
            if (w_start) r_pc <= w_a_nxt[ADDR_W-1:0];
`ifdef LOADER_CSUM_EN
            if (w_hs) r_csum <= w_clr ? i_rx_data : r_csum ^ i_rx_data;
`endif
        end
    end
endmodule

// File: tb/tb_s_core_boot_loader.sv
// tb_s_core_boot_loader: record-level reference model checked every cycle, plus directed literal cases.
// Honours LOADER_CSUM_EN to append checksum bytes and run the checksum cases.
module tb_s_core_boot_loader;
`ifdef LOADER_CSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif
    logic        clk = 1'b0, rst_n = 1'b1;
    logic [7:0]  i_rx_data = 8'h00;
    logic        i_rx_valid = 1'b0;
    logic        o_rx_ready, o_setup, o_inst_mem_we, o_load_reg_we, o_err;
    logic [31:0] o_inst_mem_addr, o_inst_mem_data, o_load_reg_data, o_pc_instr_start_addr;
    logic [4:0]  o_load_reg_addr;
    int total = 0, bad = 0;

    s_core_boot_loader dut (
        .clk(clk), .rst_n(rst_n), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
        .o_rx_ready(o_rx_ready), .o_setup(o_setup),
        .o_inst_mem_addr(o_inst_mem_addr), .o_inst_mem_data(o_inst_mem_data), .o_inst_mem_we(o_inst_mem_we),
        .o_load_reg_addr(o_load_reg_addr), .o_load_reg_data(o_load_reg_data), .o_load_reg_we(o_load_reg_we),
        .o_pc_instr_start_addr(o_pc_instr_start_addr), .o_err(o_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: collects accepted bytes into a record and applies it when complete.
    logic [7:0]  m_rec[$];
    logic        m_run = 0, m_commit = 0, m_rdy_ok = 0, m_err = 0, m_iwe = 0, m_rwe = 0, m_hs;
    logic [31:0] m_ia = 0, m_id = 0, m_rd = 0, m_pc = 0;
    logic [4:0]  m_ra = 0;
    logic [7:0]  m_x;

    function automatic int rec_len(input logic [7:0] op);
        return (op == 8'h01 ? 9 : op == 8'h02 ? 6 : 5) + (CS ? 1 : 0);
    endfunction
    function automatic logic [31:0] le(input int s);
        return {m_rec[s+3], m_rec[s+2], m_rec[s+1], m_rec[s]};
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_rec.delete();
            {m_run, m_commit, m_rdy_ok, m_err, m_iwe, m_rwe} = '0;
            {m_ia, m_id, m_rd, m_pc, m_ra} = '0;
        end else begin
            m_hs = i_rx_valid && m_rdy_ok && !m_commit && !m_run;
            {m_iwe, m_rwe, m_commit} = '0;
            m_rdy_ok = 1'b1;
            if (m_hs) begin
                m_rec.push_back(i_rx_data);
                if (m_rec[0] < 8'h01 || m_rec[0] > 8'h03) begin
                    m_err = 1'b1;
                    m_rec.delete();
                end else if (m_rec.size() == rec_len(m_rec[0])) begin
                    m_x = 8'h00;
                    for (int k = 0; k < m_rec.size() - 1; k++) m_x ^= m_rec[k];
                    if (CS && m_x != m_rec[m_rec.size()-1]) m_err = 1'b1;
                    else if (m_rec[0] == 8'h01) begin
                        m_iwe = 1'b1; m_commit = 1'b1; m_ia = le(1); m_id = le(5);
                    end else if (m_rec[0] == 8'h02) begin
                        m_commit = 1'b1;
                        if (m_rec[1][4:0] != 5'd0) begin
                            m_rwe = 1'b1; m_ra = m_rec[1][4:0]; m_rd = le(2);
                        end
                    end else begin
                        m_run = 1'b1; m_pc = le(1);
                    end
                    m_rec.delete();
                end
            end
        end
    end

    int n_iwe = 0, n_rwe = 0;
    logic [31:0] l_ia = 0, l_id = 0, l_rd = 0;
    logic [4:0]  l_ra = 0;

    initial forever begin
        @(negedge clk);
        chk("iwe", o_inst_mem_we, m_iwe);
        chk("rwe", o_load_reg_we, m_rwe);
        chk("setup", o_setup, !m_run);
        chk("ready", o_rx_ready, m_rdy_ok && !m_commit && !m_run);
        chk("err", o_err, m_err);
        chk("iaddr", o_inst_mem_addr, m_ia);
        chk("idata", o_inst_mem_data, m_id);
        chk("raddr", o_load_reg_addr, m_ra);
        chk("rdata", o_load_reg_data, m_rd);
        chk("pc", o_pc_instr_start_addr, m_pc);
        if (o_inst_mem_we) begin n_iwe++; l_ia = o_inst_mem_addr; l_id = o_inst_mem_data; end
        if (o_load_reg_we) begin n_rwe++; l_ra = o_load_reg_addr; l_rd = o_load_reg_data; end
    end

    task automatic put(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) begin
            @(negedge clk);
            i_rx_valid = 1'b0;
            i_rx_data  = 8'($urandom);
        end
        @(negedge clk);
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        n = 0;
        while (!o_rx_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("put_timeout_ready", {31'd0, o_rx_ready}, 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            i_rx_valid = 1'b0;
        end
    endtask

    task automatic send_rec(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d,
                            input bit badcs, input int maxgap);
        logic [7:0] q[$];
        logic [7:0] x;
        q.push_back(op);
        if (op == 8'h01 || op == 8'h03) for (int k = 0; k < 4; k++) q.push_back(a[8*k +: 8]);
        if (op == 8'h02) q.push_back(a[7:0]);
        if (op == 8'h01 || op == 8'h02) for (int k = 0; k < 4; k++) q.push_back(d[8*k +: 8]);
        if (CS && op >= 8'h01 && op <= 8'h03) begin
            x = 8'h00;
            foreach (q[k]) x ^= q[k];
            q.push_back(badcs ? ~x : x);
        end
        foreach (q[k]) put(q[k], $urandom_range(0, maxgap));
    endtask

    task automatic do_reset;
        @(negedge clk);
        #1 rst_n = 1'b0;
        i_rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    int b0;
    logic [31:0] rpc;
    logic [7:0]  rb;
    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_ready", {31'd0, o_rx_ready}, 32'd0);
        chk("rst_setup", {31'd0, o_setup}, 32'd1);
        chk("rst_err", {31'd0, o_err}, 32'd0);
        chk("rst_iaddr", o_inst_mem_addr, 32'd0);
        @(negedge clk);
        chk("rst_ready_after", {31'd0, o_rx_ready}, 32'd1);
        // T1
        b0 = n_iwe;
        send_rec(8'h01, 32'h4, 32'h00127413, 0, 0);
        idle(2);
        chk("t1_cnt", n_iwe - b0, 1);
        chk("t1_addr", l_ia, 32'h00000004);
        chk("t1_data", l_id, 32'h00127413);
        chk("t1_setup", {31'd0, o_setup}, 32'd1);
        // T2
        b0 = n_rwe;
        send_rec(8'h02, 32'h4, 32'h1, 0, 1);
        idle(2);
        chk("t2_cnt", n_rwe - b0, 1);
        chk("t2_addr", {27'd0, l_ra}, 32'd4);
        chk("t2_data", l_rd, 32'h1);
        b0 = n_rwe;
        send_rec(8'h02, 32'h0, 32'hffff, 0, 0);
        idle(2);
        chk("t2_x0_cnt", n_rwe - b0, 0);
        chk("t2_x0_err", {31'd0, o_err}, 32'd0);
        // T4
        send_rec(8'h7f, 0, 0, 0, 0);
        idle(2);
        chk("t4_err", {31'd0, o_err}, 32'd1);
        b0 = n_iwe;
        send_rec(8'h01, 32'h00000102, 32'hdeadbeef, 0, 0);
        idle(2);
        chk("t4_cnt", n_iwe - b0, 1);
        chk("t4_addr", l_ia, 32'h00000102);
        chk("t4_err_sticky", {31'd0, o_err}, 32'd1);
        // T5
        b0 = n_iwe;
        put(8'h01, 0); put(8'h04, 0); put(8'h00, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        i_rx_valid = 1'b0;
        #1 chk("t5_setup_async", {31'd0, o_setup}, 32'd1);
        chk("t5_ready", {31'd0, o_rx_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        chk("t5_nostrobe", n_iwe - b0, 0);
        send_rec(8'h01, 32'h10, 32'h11223344, 0, 2);
        idle(2);
        chk("t5_cnt", n_iwe - b0, 1);
        chk("t5_data", l_id, 32'h11223344);
`ifdef LOADER_CSUM_EN
        // T6
        b0 = n_iwe;
        send_rec(8'h01, 32'h20, 32'hcafef00d, 1, 0);
        idle(2);
        chk("t6_bad_cnt", n_iwe - b0, 0);
        chk("t6_bad_err", {31'd0, o_err}, 32'd1);
        send_rec(8'h01, 32'h20, 32'hcafef00d, 0, 0);
        idle(2);
        chk("t6_good_cnt", n_iwe - b0, 1);
        chk("t6_good_data", l_id, 32'hcafef00d);
`endif
        // T3
        send_rec(8'h03, 32'h4, 0, 0, 0);
        chk("t3_setup_before", {31'd0, o_setup}, 32'd1);
        idle(1);
        chk("t3_setup", {31'd0, o_setup}, 32'd0);
        chk("t3_pc", o_pc_instr_start_addr, 32'h4);
        idle(3);
        chk("t3_ready", {31'd0, o_rx_ready}, 32'd0);
        // Randomized record stream, checked by the model each cycle.
        do_reset();
        repeat (60) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: send_rec(8'h01, $urandom, $urandom, 0, 2);
                4, 5, 6, 7: begin
                    rb = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
                    send_rec(8'h02, {24'd0, rb}, $urandom, 0, 2);
                end
                8: begin
                    rb = 8'($urandom);
                    if (rb >= 8'h01 && rb <= 8'h03) rb = 8'h00;
                    send_rec(rb, 0, 0, 0, 1);
                end
                default: send_rec(8'h01, $urandom, $urandom, 1, 1);
            endcase
        end
        rpc = $urandom;
        send_rec(8'h03, rpc, 0, 0, 1);
        idle(3);
        chk("rand_setup", {31'd0, o_setup}, 32'd0);
        chk("rand_pc", o_pc_instr_start_addr, rpc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
